realtime_decimating_averager: RTL and testbench

- Downstream consumer of a multi-channel realtime parallel stream; no backpressure exists anywhere on this path.
- Each channel independently accumulates 2^L valid signed samples, then emits one averaged sample (sum arithmetically shifted right by L).
- Output is another realtime parallel stream at reduced rate, fed to downstream buffering and discrimination stages.
- L is runtime-configurable; applying a new L flushes all partial accumulations.

---
 rtl/realtime_decimating_averager_pkg.sv | 13 +
 rtl/realtime_decimating_averager_if.sv | 16 +
 rtl/realtime_decimating_averager_channel.sv | 62 ++++++
 rtl/realtime_decimating_averager.sv | 58 +++++
 tb/tb_realtime_decimating_averager.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/realtime_decimating_averager_pkg.sv
// Shared defaults and helpers for the realtime decimating averager.
// Imported by the interface, the per-channel averager and the top level.
package realtime_decimating_averager_pkg;

    localparam int unsigned DEF_DWIDTH   = 16;
    localparam int unsigned DEF_CHANNELS = 8;
    localparam int unsigned DEF_MAX_LOG2 = 6;

    function automatic int unsigned clamp_log2(input int unsigned req, input int unsigned max_log2);
        return (req > max_log2) ? max_log2 : req;
    endfunction

endpackage

// File: rtl/realtime_decimating_averager_if.sv
// Realtime parallel stream: per-channel valid and data, no backpressure.
// The master drives both fields; the slave only observes them.
interface Realtime_Parallel_If
    import realtime_decimating_averager_pkg::*;
#(
    parameter int unsigned DWIDTH   = DEF_DWIDTH,
    parameter int unsigned CHANNELS = DEF_CHANNELS
) ();

    logic [CHANNELS-1:0]             valid;
    logic [CHANNELS-1:0][DWIDTH-1:0] data;

    modport Master (output valid, output data);
    modport Slave  (input  valid, input  data);

endinterface

// File: rtl/realtime_decimating_averager_channel.sv
// One channel of the averager: accumulates 2^L signed samples and emits
// their floor average as a single-cycle pulse; flush drops the partial window.
module realtime_averager_channel
    import realtime_decimating_averager_pkg::*;
#(
    parameter int unsigned DWIDTH   = DEF_DWIDTH,
    parameter int unsigned MAX_LOG2 = DEF_MAX_LOG2,
    parameter int unsigned LW       = $clog2(MAX_LOG2 + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DWIDTH-1:0] sample,
    input  logic                     valid,
    input  logic [LW-1:0]            l,
    input  logic                     flush,
    output logic [DWIDTH-1:0]        avg,
    output logic                     avg_valid
);

    localparam int unsigned ACC_WIDTH = DWIDTH + MAX_LOG2;
    localparam int unsigned CNT_WIDTH = MAX_LOG2;

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] sum;
    logic [CNT_WIDTH-1:0]        cnt;
    logic [CNT_WIDTH-1:0]        last_cnt;
    logic [DWIDTH-1:0]           avg_next;

    // The window-closing sample is folded in before the shift, so the
    // accumulator never has to hold the full 2^L-sample sum.
    always_comb begin
        sum      = acc + ACC_WIDTH'(sample);
        last_cnt = CNT_WIDTH'((32'd1 << l) - 32'd1);
        avg_next = DWIDTH'(sum >>> l);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            cnt       <= '0;
            avg       <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (flush) begin
                acc <= '0;
                cnt <= '0;
            end else if (valid) begin
                if (cnt == last_cnt) begin
                    avg       <= avg_next;
                    avg_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/realtime_decimating_averager.sv
// Multi-channel decimating averager: owns the runtime L register, its clamp
// and the sticky config error; per-channel work lives in realtime_averager_channel.
module realtime_decimating_averager
    import realtime_decimating_averager_pkg::*;
#(
    parameter int unsigned DWIDTH   = DEF_DWIDTH,
    parameter int unsigned CHANNELS = DEF_CHANNELS,
    parameter int unsigned MAX_LOG2 = DEF_MAX_LOG2
) (
    input  logic                             clk,
    input  logic                             reset,
    Realtime_Parallel_If.Slave               data_in,
    Realtime_Parallel_If.Master              data_out,
    input  logic [$clog2(MAX_LOG2+1)-1:0]    cfg_log2_n,
    input  logic                             cfg_valid,
    output logic                             cfg_error
);

    localparam int unsigned LW = $clog2(MAX_LOG2 + 1);

    logic [LW-1:0]       l;
    logic [DWIDTH-1:0]   avg [CHANNELS];
    logic [CHANNELS-1:0] avg_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l         <= '0;
            cfg_error <= 1'b0;
        end else if (cfg_valid) begin
            l <= LW'(clamp_log2(32'(cfg_log2_n), MAX_LOG2));
            if (32'(cfg_log2_n) > MAX_LOG2) begin
                cfg_error <= 1'b1;
            end
        end
    end

    // cfg_valid doubles as flush, so a config cycle discards that cycle's samples.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        realtime_averager_channel #(
            .DWIDTH   (DWIDTH),
            .MAX_LOG2 (MAX_LOG2),
            .LW       (LW)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .sample    (data_in.data[i]),
            .valid     (data_in.valid[i]),
            .l         (l),
            .flush     (cfg_valid),
            .avg       (avg[i]),
            .avg_valid (avg_valid[i])
        );
        assign data_out.data[i] = avg[i];
    end

    assign data_out.valid = avg_valid;

endmodule

// File: tb/tb_realtime_decimating_averager.sv
// Self-checking bench for realtime_decimating_averager: directed scenarios plus
// randomized traffic checked against a queue-based floor-average model.
module tb_realtime_decimating_averager;

    localparam int DW = 16;
    localparam int CH = 8;
    localparam int ML = 6;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [LW-1:0] cfg_log2_n = '0;
    logic          cfg_valid = 1'b0;
    logic          cfg_error;

    Realtime_Parallel_If #(.DWIDTH(DW), .CHANNELS(CH)) in_if ();
    Realtime_Parallel_If #(.DWIDTH(DW), .CHANNELS(CH)) out_if ();

    realtime_decimating_averager #(
        .DWIDTH   (DW),
        .CHANNELS (CH),
        .MAX_LOG2 (ML)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (in_if),
        .data_out   (out_if),
        .cfg_log2_n (cfg_log2_n),
        .cfg_valid  (cfg_valid),
        .cfg_error  (cfg_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: raw samples queued per channel, averaged when the window fills.
    int          m_l;
    bit          m_err;
    bit [CH-1:0] m_valid;
    logic [DW-1:0] m_data [CH];
    int          m_q [CH][$];

    function automatic int floor_avg(input longint s, input int l);
        longint n;
        longint q;
        n = longint'(1) << l;
        q = s / n;
        if (s < 0 && q * n != s) q = q - 1;
        return int'(q);
    endfunction

    task automatic model_reset();
        m_l     = 0;
        m_err   = 1'b0;
        m_valid = '0;
        for (int c = 0; c < CH; c++) begin
            m_data[c] = '0;
            m_q[c].delete();
        end
    endtask

    task automatic tick();
        longint s;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else if (cfg_valid) begin
            m_l = (int'(cfg_log2_n) > ML) ? ML : int'(cfg_log2_n);
            if (int'(cfg_log2_n) > ML) m_err = 1'b1;
            m_valid = '0;
            for (int c = 0; c < CH; c++) m_q[c].delete();
        end else begin
            for (int c = 0; c < CH; c++) begin
                m_valid[c] = 1'b0;
                if (in_if.valid[c]) begin
                    m_q[c].push_back(int'($signed(in_if.data[c])));
                    if (m_q[c].size() == (1 << m_l)) begin
                        s = 0;
                        foreach (m_q[c][k]) s += m_q[c][k];
                        m_data[c]  = DW'(floor_avg(s, m_l));
                        m_valid[c] = 1'b1;
                        m_q[c].delete();
                    end
                end
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        in_if.valid = '0;
        cfg_valid   = 1'b0;
    endtask

    task automatic apply_cfg(input int l);
        idle_inputs();
        cfg_log2_n = LW'(l);
        cfg_valid  = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        in_if.data = '0;
        tick();
        tick();
        n_checks++;
        if (out_if.valid !== '0) $display("FAIL reset_valid: got %b want %b", out_if.valid, 8'h00);
        else n_pass++;
        n_checks++;
        if (out_if.data !== '0) $display("FAIL reset_data: got %h want 0", out_if.data);
        else n_pass++;
        n_checks++;
        if (cfg_error !== 1'b0) $display("FAIL reset_cfg_error: got %b want 0", cfg_error);
        else n_pass++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_passthrough();
        logic [CH-1:0]         pv;
        logic [CH-1:0][DW-1:0] pd;
        bit bad;
        for (int t = 0; t < 60; t++) begin
            pv = CH'($urandom);
            pd = {$urandom, $urandom, $urandom, $urandom};
            in_if.valid = pv;
            in_if.data  = pd;
            tick();
            n_checks++;
            if (out_if.valid !== pv) $display("FAIL pass_valid t=%0d: got %b want %b", t, out_if.valid, pv);
            else n_pass++;
            bad = 1'b0;
            for (int c = 0; c < CH; c++)
                if (pv[c] && out_if.data[c] !== pd[c]) bad = 1'b1;
            n_checks++;
            if (bad) $display("FAIL pass_data t=%0d: got %h want %h (valid %b)", t, out_if.data, pd, pv);
            else n_pass++;
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_l2_directed();
        int a [4] = '{1, 2, 3, 6};
        int b [4] = '{-1, -1, -1, -2};
        apply_cfg(2);
        n_checks++;
        if (out_if.valid !== '0) $display("FAIL l2_cfg_valid: got %b want 0", out_if.valid);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            in_if.valid   = 8'b0000_0011;
            in_if.data[0] = DW'(a[k]);
            in_if.data[1] = DW'(b[k]);
            tick();
            if (k < 3) begin
                n_checks++;
                if (out_if.valid !== '0) $display("FAIL l2_early_valid k=%0d: got %b want 0", k, out_if.valid);
                else n_pass++;
            end
        end
        n_checks++;
        if (out_if.valid !== 8'b0000_0011) $display("FAIL l2_pulse: got %b want %b", out_if.valid, 8'b0000_0011);
        else n_pass++;
        n_checks++;
        if (out_if.data[0] !== 16'd3) $display("FAIL l2_avg_ch0: got %h want %h", out_if.data[0], 16'd3);
        else n_pass++;
        n_checks++;
        if (out_if.data[1] !== 16'hFFFE) $display("FAIL l2_avg_ch1: got %h want %h", out_if.data[1], 16'hFFFE);
        else n_pass++;
        idle_inputs();
        tick();
        n_checks++;
        if (out_if.valid !== '0 || out_if.data[0] !== 16'd3)
            $display("FAIL l2_hold: got valid %b data %h want valid 0 data %h", out_if.valid, out_if.data[0], 16'd3);
        else n_pass++;
    endtask

    task automatic test_l3_sparse();
        int pulses [CH];
        int pulse_t;
        apply_cfg(3);
        foreach (pulses[c]) pulses[c] = 0;
        pulse_t = -1;
        for (int t = 0; t < 27; t++) begin
            in_if.valid    = '0;
            in_if.valid[3] = (t % 3 == 0) && (t < 24);
            in_if.data[3]  = 16'h7FFF;
            in_if.data[4]  = DW'($urandom);
            tick();
            for (int c = 0; c < CH; c++) if (out_if.valid[c]) pulses[c]++;
            if (out_if.valid[3]) pulse_t = t;
            n_checks++;
            if (out_if.valid !== m_valid) $display("FAIL l3_valid t=%0d: got %b want %b", t, out_if.valid, m_valid);
            else n_pass++;
        end
        n_checks++;
        if (pulses[3] != 1 || pulse_t != 21) $display("FAIL l3_pulse_ch3: got %0d pulses at t=%0d want 1 at t=21", pulses[3], pulse_t);
        else n_pass++;
        n_checks++;
        if (pulses[4] != 0) $display("FAIL l3_idle_ch4: got %0d pulses want 0", pulses[4]);
        else n_pass++;
        n_checks++;
        if (out_if.data[3] !== 16'h7FFF) $display("FAIL l3_avg: got %h want %h", out_if.data[3], 16'h7FFF);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_cfg_collision();
        int pre [3] = '{100, 200, 300};
        apply_cfg(2);
        for (int k = 0; k < 3; k++) begin
            in_if.valid   = 8'h01;
            in_if.data[0] = DW'(pre[k]);
            tick();
        end
        in_if.valid   = 8'h01;
        in_if.data[0] = 16'd400;
        cfg_log2_n    = 3'd1;
        cfg_valid     = 1'b1;
        tick();
        cfg_valid = 1'b0;
        n_checks++;
        if (out_if.valid !== '0) $display("FAIL collide_valid: got %b want 0", out_if.valid);
        else n_pass++;
        in_if.data[0] = 16'd10;
        tick();
        n_checks++;
        if (out_if.valid !== '0) $display("FAIL collide_first: got %b want 0", out_if.valid);
        else n_pass++;
        in_if.data[0] = 16'd20;
        tick();
        n_checks++;
        if (out_if.valid !== 8'h01 || out_if.data[0] !== 16'd15)
            $display("FAIL collide_avg: got valid %b data %h want valid %b data %h", out_if.valid, out_if.data[0], 8'h01, 16'd15);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_cfg_error();
        apply_cfg(ML + 1);
        n_checks++;
        if (cfg_error !== 1'b1) $display("FAIL cfgerr_set: got %b want 1", cfg_error);
        else n_pass++;
        for (int k = 0; k < 64; k++) begin
            in_if.valid = '1;
            for (int c = 0; c < CH; c++) in_if.data[c] = 16'd5;
            tick();
            if (k < 63) begin
                if (out_if.valid !== '0) begin
                    n_checks++;
                    $display("FAIL cfgerr_early k=%0d: got %b want 0", k, out_if.valid);
                end
            end
        end
        n_checks++;
        if (out_if.valid !== '1) $display("FAIL cfgerr_pulse: got %b want %b", out_if.valid, 8'hFF);
        else n_pass++;
        n_checks++;
        if (out_if.data !== {CH{16'd5}}) $display("FAIL cfgerr_avg: got %h want all 0005", out_if.data);
        else n_pass++;
        idle_inputs();
        tick();
        n_checks++;
        if (cfg_error !== 1'b1) $display("FAIL cfgerr_sticky: got %b want 1", cfg_error);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        apply_cfg(2);
        for (int k = 0; k < 2; k++) begin
            in_if.valid   = 8'h01;
            in_if.data[0] = 16'd7;
            tick();
        end
        idle_inputs();
        reset = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (out_if.valid !== '0 || out_if.data !== '0)
            $display("FAIL areset_out: got valid %b data %h want 0", out_if.valid, out_if.data);
        else n_pass++;
        n_checks++;
        if (cfg_error !== 1'b0) $display("FAIL areset_cfg_error: got %b want 0", cfg_error);
        else n_pass++;
        reset = 1'b0;
        in_if.valid   = 8'h01;
        in_if.data[0] = 16'd9;
        tick();
        n_checks++;
        if (out_if.valid !== 8'h01 || out_if.data[0] !== 16'd9)
            $display("FAIL areset_recover: got valid %b data %h want valid %b data %h", out_if.valid, out_if.data[0], 8'h01, 16'd9);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_random();
        bit bad;
        int bad_c;
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 39) == 0) begin
                cfg_valid  = 1'b1;
                cfg_log2_n = ($urandom_range(0, 9) == 0) ? LW'($urandom_range(ML, 7)) : LW'($urandom_range(0, 3));
            end else begin
                cfg_valid = 1'b0;
            end
            in_if.valid = CH'($urandom) | CH'($urandom);
            in_if.data  = {$urandom, $urandom, $urandom, $urandom};
            tick();
            n_checks++;
            if (out_if.valid !== m_valid) $display("FAIL rand_valid t=%0d: got %b want %b", t, out_if.valid, m_valid);
            else n_pass++;
            bad   = 1'b0;
            bad_c = 0;
            for (int c = 0; c < CH; c++)
                if (!bad && out_if.data[c] !== m_data[c]) begin
                    bad   = 1'b1;
                    bad_c = c;
                end
            n_checks++;
            if (bad) $display("FAIL rand_data t=%0d ch=%0d: got %h want %h", t, bad_c, out_if.data[bad_c], m_data[bad_c]);
            else n_pass++;
            n_checks++;
            if (cfg_error !== m_err) $display("FAIL rand_cfg_error t=%0d: got %b want %b", t, cfg_error, m_err);
            else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        in_if.valid = '0;
        in_if.data  = '0;
        model_reset();
        test_reset();
        test_passthrough();
        test_l2_directed();
        test_l3_sparse();
        test_cfg_collision();
        test_cfg_error();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
